// File: rtl/spi_master_param_if.sv
// SPI master bus bundle: CPU-side request/response plus the serial pins.
// The master modport is the design's view; the slave modport is the driver side.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int N_CS   = 1
);
  localparam int CSW = (N_CS > 1) ? $clog2(N_CS) : 1;

  logic              CKP;
  logic              CPH;
  logic              strt;
  logic [DATA_W-1:0] data_in;
  logic [CSW-1:0]    cs_sel;
  logic              MISO;
  logic              MOSI;
  logic              SCK;
  logic [N_CS-1:0]   CS;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;

  modport master (
    input  CKP, CPH, strt, data_in, cs_sel, MISO,
    output MOSI, SCK, CS, data_out, busy, done
  );

  modport slave (
    output CKP, CPH, strt, data_in, cs_sel, MISO,
    input  MOSI, SCK, CS, data_out, busy, done
  );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit MSB-first full-duplex transfers in all
// four CKP/CPH modes, SCK = clk/(2*DIV), one of N_CS active-low selects.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int DIV    = 2,
  parameter int N_CS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_param_if.master bus
);
  localparam int CSW  = (N_CS > 1) ? $clog2(N_CS) : 1;
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(2*DATA_W);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;

  state_e            state_q, state_d;
  logic [DIVW-1:0]   div_cnt_q, div_cnt_d;
  logic [TW-1:0]     tog_cnt_q, tog_cnt_d;
  logic              ckp_q, ckp_d;
  logic              cph_q, cph_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_CS-1:0]   cs_q, cs_d;

  logic div_last, sample_edge, last_tog;

  // Out-of-range selects decode to no line asserted.
  function automatic logic [N_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [N_CS-1:0] m;
    m = '1;
    for (int i = 0; i < N_CS; i++)
      if (sel == CSW'(i)) m[i] = 1'b0;
    return m;
  endfunction

  assign div_last    = (div_cnt_q == DIVW'(DIV-1));
  // Toggle number tog_cnt_q+1: odd = leading edge. Sample on leading when CPH=0, trailing when CPH=1.
  assign sample_edge = ~tog_cnt_q[0] ^ cph_q;
  assign last_tog    = (tog_cnt_q == TW'(2*DATA_W-1));

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    tog_cnt_d  = tog_cnt_q;
    ckp_d      = ckp_q;
    cph_d      = cph_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_d       = cs_q;
    case (state_q)
      IDLE: begin
        sck_d = bus.CKP;
        if (bus.strt) begin
          state_d   = LEAD;
          ckp_d     = bus.CKP;
          cph_d     = bus.CPH;
          div_cnt_d = '0;
          tog_cnt_d = '0;
          rx_d      = '0;
          busy_d    = 1'b1;
          cs_d      = cs_decode(bus.cs_sel);
          if (!bus.CPH) begin
            mosi_d = bus.data_in[DATA_W-1];
            tx_d   = bus.data_in << 1;
          end else begin
            tx_d   = bus.data_in;
          end
        end
      end
      LEAD: begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_last) begin
          div_cnt_d = '0;
          tog_cnt_d = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_last) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          tog_cnt_d = tog_cnt_q + 1'b1;
          if (sample_edge) begin
            rx_d = {rx_q[DATA_W-2:0], bus.MISO};
          end else if (!last_tog) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
          if (last_tog) state_d = TRAIL;
        end
      end
      TRAIL: begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_last) begin
          div_cnt_d  = '0;
          state_d    = IDLE;
          sck_d      = ckp_q;
          cs_d       = '1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          data_out_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      tog_cnt_q  <= '0;
      ckp_q      <= 1'b0;
      cph_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= '1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tog_cnt_q  <= tog_cnt_d;
      ckp_q      <= ckp_d;
      cph_q      <= cph_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
    end
  end

  assign bus.SCK      = sck_q;
  assign bus.MOSI     = mosi_q;
  assign bus.CS       = cs_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: edge-counting SPI slave model, per-scenario tasks,
// randomized transfers checked against expectations derived from transfer rules.
module tb_spi_master_param;
  localparam int DW  = 8;
  localparam int DV  = 2;
  localparam int NC  = 3;
  localparam int LAT = (2*DW+2)*DV + 1;

  typedef struct {
    int         lat;
    logic [7:0] dout;
    logic [7:0] mcap;
    int         nrise;
    logic [2:0] cs_low;
    logic       cs_glitch;
    logic       busy_gap;
    logic [2:0] cs_pre;
    logic [2:0] cs_post;
    logic       sck_pre;
    logic       sck_end;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(DW), .N_CS(NC)) bus ();
  spi_master_param #(.DATA_W(DW), .DIV(DV), .N_CS(NC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic       loop;
  logic [7:0] slv;
  logic       tb_cph;
  logic       slv_miso = 1'b0;
  logic       in_x = 1'b0;
  logic       sck_last = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  int         e = 0;
  int         rises = 0;

  assign bus.MISO = loop ? bus.MOSI : slv_miso;

  // Slave: counts SCK edges per transfer; shifts its word out on the non-sampling edge, captures MOSI on the sampling one.
  always @(bus.SCK or bus.busy) begin
    if (!bus.busy) in_x = 1'b0;
    else if (!in_x) begin
      in_x = 1'b1; e = 0; rises = 0; mosi_cap = 8'h00;
      if (!tb_cph) slv_miso = slv[7];
    end else if (bus.SCK !== sck_last) begin
      e++;
      if (bus.SCK) rises++;
      if (!tb_cph) begin
        if (e % 2 == 1) mosi_cap = {mosi_cap[6:0], bus.MOSI};
        else if (e < 16) slv_miso = slv[7 - e/2];
      end else begin
        if (e % 2 == 1) slv_miso = slv[7 - (e-1)/2];
        else mosi_cap = {mosi_cap[6:0], bus.MOSI};
      end
    end
    sck_last = bus.SCK;
  end

  // Called and returns at a negedge; returns in the done cycle.
  task automatic run_xfer(input logic ckp, input logic cph, input logic [7:0] d, input logic [7:0] s,
                          input logic [1:0] sel, input logic lp, input logic settle, output obs_t o);
    logic [2:0] pcs;
    logic       psck;
    tb_cph = cph; slv = s; loop = lp;
    bus.CKP = ckp; bus.CPH = cph; bus.data_in = d; bus.cs_sel = sel;
    if (settle) @(negedge clk);
    o.cs_pre = bus.CS; o.sck_pre = bus.SCK;
    bus.strt = 1'b1;
    @(negedge clk);
    bus.strt = 1'b0;
    o.cs_post = bus.CS; o.cs_low = ~bus.CS; o.cs_glitch = 1'b0; o.busy_gap = !bus.busy;
    o.lat = -1;
    pcs = bus.CS; psck = bus.SCK;
    for (int k = 1; k < 200 && o.lat < 0; k++) begin
      @(negedge clk);
      if (bus.done) o.lat = k + 1;
      else begin
        if (!bus.busy) o.busy_gap = 1'b1;
        o.cs_low |= ~bus.CS;
      end
      if (bus.CS !== pcs && (bus.SCK !== ckp || psck !== ckp)) o.cs_glitch = 1'b1;
      pcs = bus.CS; psck = bus.SCK;
    end
    o.dout = bus.data_out; o.mcap = mosi_cap; o.nrise = rises; o.sck_end = bus.SCK;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.SCK !== 1'b0 || bus.MOSI !== 1'b0) begin errors++; $display("FAIL reset_pins got SCK=%b MOSI=%b exp 0 0", bus.SCK, bus.MOSI); end
    checks++; if (bus.CS !== 3'b111) begin errors++; $display("FAIL reset_cs got %b exp 111", bus.CS); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_status got busy=%b done=%b dout=%h exp 0 0 00", bus.busy, bus.done, bus.data_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    obs_t o;
    run_xfer(1'b0, 1'b0, 8'hA5, 8'h00, 2'd0, 1'b1, 1'b1, o);
    checks++; if (o.dout !== 8'hA5) begin errors++; $display("FAIL mode0_dout got %h exp a5", o.dout); end
    checks++; if (o.lat !== LAT) begin errors++; $display("FAIL mode0_latency got %0d exp %0d", o.lat, LAT); end
    checks++; if (o.nrise !== DW) begin errors++; $display("FAIL mode0_sck_rises got %0d exp %0d", o.nrise, DW); end
    checks++; if (o.mcap !== 8'hA5) begin errors++; $display("FAIL mode0_mosi got %h exp a5", o.mcap); end
    checks++; if (o.cs_low !== 3'b001 || o.busy_gap !== 1'b0) begin errors++; $display("FAIL mode0_cs_busy got cs_low=%b gap=%b exp 001 0", o.cs_low, o.busy_gap); end
  endtask

  task automatic test_mode3();
    obs_t o;
    run_xfer(1'b1, 1'b1, 8'h3C, 8'hC3, 2'd0, 1'b0, 1'b1, o);
    checks++; if (o.dout !== 8'hC3) begin errors++; $display("FAIL mode3_dout got %h exp c3", o.dout); end
    checks++; if (o.mcap !== 8'h3C) begin errors++; $display("FAIL mode3_mosi got %h exp 3c", o.mcap); end
    checks++; if (o.sck_pre !== 1'b1 || o.cs_pre !== 3'b111) begin errors++; $display("FAIL mode3_pre got sck=%b cs=%b exp 1 111", o.sck_pre, o.cs_pre); end
    checks++; if (o.sck_end !== 1'b1 || bus.CS !== 3'b111) begin errors++; $display("FAIL mode3_post got sck=%b cs=%b exp 1 111", o.sck_end, bus.CS); end
    checks++; if (o.lat !== LAT || o.nrise !== DW || o.cs_glitch !== 1'b0) begin errors++; $display("FAIL mode3_timing got lat=%0d rises=%0d glitch=%b exp %0d %0d 0", o.lat, o.nrise, o.cs_glitch, LAT, DW); end
  endtask

  task automatic test_strt_hold();
    int first = -1, second = -1, busy_low = 0;
    logic [7:0] d1 = 8'h00, d2 = 8'h00;
    logic sck_trail = 1'bx, sck_lead2 = 1'bx;
    tb_cph = 1'b0; loop = 1'b1;
    bus.CKP = 1'b0; bus.CPH = 1'b0; bus.data_in = 8'hA5; bus.cs_sel = 2'd0;
    @(negedge clk);
    bus.strt = 1'b1;
    for (int k = 1; k <= 2*LAT + 10 && second < 0; k++) begin
      @(negedge clk);
      if (k == 10) begin bus.CKP = 1'b1; bus.data_in = 8'h66; end
      if (k == LAT - 1) sck_trail = bus.SCK;
      if (k == LAT + 1) sck_lead2 = bus.SCK;
      if (bus.done) begin
        if (first < 0) begin first = k; d1 = bus.data_out; end
        else begin second = k; d2 = bus.data_out; bus.strt = 1'b0; end
      end else if (!bus.busy) busy_low++;
    end
    bus.strt = 1'b0;
    checks++; if (first !== LAT || second !== 2*LAT) begin errors++; $display("FAIL hold_done_times got %0d %0d exp %0d %0d", first, second, LAT, 2*LAT); end
    checks++; if (d1 !== 8'hA5 || d2 !== 8'h66) begin errors++; $display("FAIL hold_data got %h %h exp a5 66", d1, d2); end
    checks++; if (sck_trail !== 1'b0 || sck_lead2 !== 1'b1) begin errors++; $display("FAIL hold_polarity got trail=%b lead2=%b exp 0 1", sck_trail, sck_lead2); end
    checks++; if (busy_low !== 0) begin errors++; $display("FAIL hold_busy got %0d low samples exp 0", busy_low); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int saw_done = 0;
    tb_cph = 1'b0; loop = 1'b1;
    bus.CKP = 1'b0; bus.CPH = 1'b0; bus.data_in = 8'hF0; bus.cs_sel = 2'd0;
    @(negedge clk);
    bus.strt = 1'b1;
    @(posedge clk);
    bus.strt = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.CS !== 3'b111 || bus.SCK !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_async got cs=%b sck=%b busy=%b exp 111 0 0", bus.CS, bus.SCK, bus.busy); end
    repeat (3) begin @(negedge clk); if (bus.done) saw_done++; end
    rst = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done) saw_done++; end
    checks++; if (saw_done !== 0 || bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_abort got dones=%0d dout=%h exp 0 00", saw_done, bus.data_out); end
    run_xfer(1'b0, 1'b0, 8'h5A, 8'h00, 2'd0, 1'b1, 1'b1, o);
    checks++; if (o.dout !== 8'h5A || o.lat !== LAT) begin errors++; $display("FAIL rst_mid_recover got dout=%h lat=%0d exp 5a %0d", o.dout, o.lat, LAT); end
  endtask

  task automatic test_cs_sel();
    obs_t o;
    run_xfer(1'b0, 1'b1, 8'h96, 8'h00, 2'd2, 1'b1, 1'b1, o);
    checks++; if (o.cs_low !== 3'b100 || o.dout !== 8'h96) begin errors++; $display("FAIL cs_sel2 got cs_low=%b dout=%h exp 100 96", o.cs_low, o.dout); end
    run_xfer(1'b1, 1'b0, 8'h69, 8'h00, 2'd3, 1'b1, 1'b1, o);
    checks++; if (o.cs_low !== 3'b000 || o.lat !== LAT || o.dout !== 8'h69) begin errors++; $display("FAIL cs_sel3 got cs_low=%b lat=%0d dout=%h exp 000 %0d 69", o.cs_low, o.lat, o.dout, LAT); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_xfer(1'b0, 1'b0, 8'h01, 8'h00, 2'd0, 1'b1, 1'b1, o1);
    run_xfer(1'b0, 1'b0, 8'h80, 8'h00, 2'd0, 1'b1, 1'b0, o2);
    checks++; if (o1.dout !== 8'h01 || o2.dout !== 8'h80) begin errors++; $display("FAIL b2b_data got %h %h exp 01 80", o1.dout, o2.dout); end
    checks++; if (o2.cs_pre !== 3'b111 || o2.cs_post !== 3'b110) begin errors++; $display("FAIL b2b_cs_gap got pre=%b post=%b exp 111 110", o2.cs_pre, o2.cs_post); end
    checks++; if (o2.lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", o2.lat, LAT); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 10; i++) begin
      logic       ckp = 1'($urandom_range(0, 1));
      logic       cph = 1'($urandom_range(0, 1));
      logic [7:0] d   = 8'($urandom);
      logic [7:0] s   = 8'($urandom);
      logic [1:0] sel = 2'($urandom_range(0, 3));
      logic [2:0] exp_cs;
      exp_cs = (int'(sel) < NC) ? (3'b001 << sel) : 3'b000;
      run_xfer(ckp, cph, d, s, sel, 1'b0, 1'b1, o);
      checks++; if (o.dout !== s || o.mcap !== d) begin errors++; $display("FAIL rand%0d_data got dout=%h mosi=%h exp %h %h", i, o.dout, o.mcap, s, d); end
      checks++; if (o.lat !== LAT || o.nrise !== DW || o.cs_low !== exp_cs || o.cs_glitch !== 1'b0) begin
        errors++; $display("FAIL rand%0d_ctrl got lat=%0d rises=%0d cs_low=%b glitch=%b exp %0d %0d %b 0", i, o.lat, o.nrise, o.cs_low, o.cs_glitch, LAT, DW, exp_cs);
      end
    end
  endtask

  initial begin
    rst = 1'b1; loop = 1'b0; slv = 8'h00; tb_cph = 1'b0;
    bus.strt = 1'b0; bus.CKP = 1'b0; bus.CPH = 1'b0; bus.data_in = '0; bus.cs_sel = '0;
    test_reset();
    test_mode0();
    test_mode3();
    test_strt_hold();
    test_reset_mid();
    test_cs_sel();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
